disp_scheduler: RTL and testbench
=================================

DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter MSG_HOLD_CYCLES, default 100000000, is the number of clk cycles a message owns the display (1 s at 100 MHz); legal values are >= 1.
REQ-002 Parameter CLAMP_MAX, default 999, is the largest current value shown numerically; legal range is 0..999.
REQ-003 clk  input  1  100 MHz system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cur_valid  input  1  current sample offered.
REQ-006 cur_data  input  12  current sample in mA, unsigned.
REQ-007 dir  input  1  motor direction: 0 = forward, 1 = reverse; sampled together with cur_data.
REQ-008 cur_ready  output  1  scheduler accepts a current sample this cycle.
REQ-009 msg_valid  input  1  message offered.
REQ-010 msg_code  input  16  four 4-bit digit codes; [15:12] is the leftmost digit.
REQ-011 msg_ready  output  1  scheduler accepts a message this cycle.
REQ-012 disp_digits  output  16  digit codes to the seven-segment driver: 0-9 decimal, A "r", B "F", E "-", F blank; [15:12] is the leftmost digit.
REQ-013 disp_update  output  1  one-cycle pulse when disp_digits changes.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM shall have exactly three states: IDLE, CONVERT and SHOW_MSG.
REQ-016 A transfer shall occur on any cycle where valid and ready are both high at the rising clk edge.
REQ-017 In IDLE, cur_ready and msg_ready shall be 1; in CONVERT, both shall be 0; in SHOW_MSG, msg_ready shall be 1 and cur_ready 0.
REQ-018 In IDLE with msg_valid and cur_valid both high, the message shall win and cur_ready shall be forced to 0 that cycle.
REQ-019 IDLE to CONVERT on a current transfer: latch min(cur_data, CLAMP_MAX) and dir.
REQ-020 CONVERT shall perform 12-cycle sequential shift-add-3 binary-to-BCD conversion, one bit per cycle, MSB first.
REQ-021 The current transfer at edge T shall produce updated disp_digits and a disp_update pulse at edge T+13, with a return to IDLE on the same edge.
REQ-022 Current display format: [15:12] = A if dir = 1, otherwise B; [11:0] = hundreds, tens, ones as BCD.
REQ-023 IDLE to SHOW_MSG on a message transfer: at the next edge, disp_digits = msg_code, disp_update pulses, and the hold counter loads MSG_HOLD_CYCLES.
REQ-024 In SHOW_MSG, the hold counter shall decrement once per cycle; SHOW_MSG to IDLE on the edge where the counter reaches 0. A message transfer at T returns to IDLE at T+1+MSG_HOLD_CYCLES.
REQ-025 A message transfer during SHOW_MSG shall replace disp_digits, pulse disp_update and reload the hold counter; a transfer on the expiry cycle takes precedence over expiry.
REQ-026 disp_digits shall hold its value between updates; the display is not blanked when a hold expires.
REQ-027 The hold counter width shall be $clog2(MSG_HOLD_CYCLES+1) bits; the conversion shift register shall be 12 + 12 bits.

Reset
REQ-028 While rst_n = 0, independent of clk: state = IDLE, disp_digits = 16'hFFFF, disp_update = 0, busy = 0, hold counter = 0, conversion registers = 0.
REQ-029 Assertion of rst_n mid-CONVERT or mid-SHOW_MSG shall abort the operation with no disp_update pulse.
REQ-030 The first transfer shall be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro DISP_OVERRANGE_EN defined: cur_data > CLAMP_MAX shall display [11:0] = 12'hEEE (dashes) with the direction digit still shown, after the same T+13 latency.
REQ-032 Macro DISP_OVERRANGE_EN undefined: cur_data > CLAMP_MAX shall be clamped to CLAMP_MAX and displayed numerically.

Verification (MSG_HOLD_CYCLES = 8, CLAMP_MAX = 999)
REQ-033 Current path: cur_data = 12'd457, dir = 0, transfer at T -> at T+13, disp_digits = 16'hB457 with a single disp_update pulse; cur_ready = 0 during T+1..T+12.
REQ-034 Simultaneous offers in IDLE: msg_code = 16'hEEEE with cur_data = 12'd5 -> message accepted, cur_ready = 0; disp_digits = 16'hEEEE at T+1; IDLE at T+9; the current sample is accepted afterwards and produces 16'hB005.
REQ-035 Overrange: cur_data = 12'd4095, dir = 1 -> 16'hA999 without the macro, 16'hAEEE with DISP_OVERRANGE_EN.
REQ-036 Message retrigger: second message 16'h1234 at T+5 -> disp_digits = 16'h1234 at T+6; IDLE reached at T+14, not T+9.
REQ-037 Reset mid-operation: rst_n low at T+6 of a conversion -> disp_digits = 16'hFFFF immediately, no pulse; the next sample 12'd0 with dir = 0 produces 16'hB000.
REQ-038 Boundary values: cur_data = 12'd999 -> 16'hB999; cur_data = 12'd1000 -> clamped or dashed per REQ-031/REQ-032; cur_data = 12'd10 -> 16'hB010.

Source files
------------

// File: rtl/disp_scheduler.sv
// Display scheduler: converts current samples to BCD and time-shares the display with held messages.
// Optional feature: define DISP_OVERRANGE_EN to show dashes instead of clamping over-range samples.
module disp_scheduler #(
    parameter int unsigned MSG_HOLD_CYCLES = 100000000,
    parameter int unsigned CLAMP_MAX       = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cur_valid,
    input  logic [11:0] cur_data,
    input  logic        dir,
    output logic        cur_ready,
    input  logic        msg_valid,
    input  logic [15:0] msg_code,
    output logic        msg_ready,
    output logic [15:0] disp_digits,
    output logic        disp_update,
    output logic        busy
);

    localparam int unsigned HW = $clog2(MSG_HOLD_CYCLES + 1);
    localparam int unsigned BW = 12;
    localparam int unsigned SW = BW + 12;
    localparam int unsigned CW = 4;
    localparam logic [BW-1:0] CLAMP     = BW'(CLAMP_MAX);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MSG_HOLD_CYCLES);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BW);

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW_MSG} state_t;

    state_t        state, state_n;
    logic [SW-1:0] shreg, shreg_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic          dir_q, dir_n;
    logic [HW-1:0] hold, hold_n;
    logic [15:0]   msg_buf, msg_buf_n;
    logic          msg_pend, msg_pend_n;
    logic [15:0]   disp_n;
    logic          upd_n;
`ifdef DISP_OVERRANGE_EN
    logic          over_q, over_n;
`endif

    // One shift-add-3 iteration over the three BCD digits in the upper half
    function automatic logic [SW-1:0] bcd_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[BW+4*i +: 4] >= 4'd5)
                t[BW+4*i +: 4] = t[BW+4*i +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        dir_n      = dir_q;
        hold_n     = hold;
        msg_buf_n  = msg_buf;
        msg_pend_n = msg_pend;
        disp_n     = disp_digits;
        upd_n      = 1'b0;
        cur_ready  = 1'b0;
        msg_ready  = 1'b0;
`ifdef DISP_OVERRANGE_EN
        over_n     = over_q;
`endif
        case (state)
            IDLE: begin
                msg_ready = 1'b1;
                cur_ready = !msg_valid;
                if (msg_valid) begin
                    msg_buf_n  = msg_code;
                    msg_pend_n = 1'b1;
                    state_n    = SHOW_MSG;
                end else if (cur_valid) begin
                    shreg_n   = {12'd0, (cur_data > CLAMP) ? CLAMP : cur_data};
                    dir_n     = dir;
                    bit_cnt_n = '0;
                    state_n   = CONVERT;
`ifdef DISP_OVERRANGE_EN
                    over_n    = (cur_data > CLAMP);
`endif
                end
            end
            CONVERT: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef DISP_OVERRANGE_EN
                    disp_n = {dir_q ? 4'hA : 4'hB, over_q ? 12'hEEE : shreg[SW-1:BW]};
`else
                    disp_n = {dir_q ? 4'hA : 4'hB, shreg[SW-1:BW]};
`endif
                    upd_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    shreg_n   = bcd_step(shreg);
                    bit_cnt_n = bit_cnt + CW'(1);
                end
            end
            SHOW_MSG: begin
                msg_ready = 1'b1;
                // A pending message is shown one edge after its transfer; new offers never let the hold expire
                if (msg_pend) begin
                    disp_n     = msg_buf;
                    upd_n      = 1'b1;
                    hold_n     = HOLD_LOAD;
                    msg_pend_n = msg_valid;
                    if (msg_valid)
                        msg_buf_n = msg_code;
                end else if (msg_valid) begin
                    msg_buf_n  = msg_code;
                    msg_pend_n = 1'b1;
                end else begin
                    hold_n = hold - HW'(1);
                    if (hold == HW'(1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            dir_q       <= 1'b0;
            hold        <= '0;
            msg_buf     <= '0;
            msg_pend    <= 1'b0;
            disp_digits <= 16'hFFFF;
            disp_update <= 1'b0;
            busy        <= 1'b0;
`ifdef DISP_OVERRANGE_EN
            over_q      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            dir_q       <= dir_n;
            hold        <= hold_n;
            msg_buf     <= msg_buf_n;
            msg_pend    <= msg_pend_n;
            disp_digits <= disp_n;
            disp_update <= upd_n;
            busy        <= (state_n != IDLE);
`ifdef DISP_OVERRANGE_EN
            over_q      <= over_n;
`endif
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: table of current samples plus message, retrigger, expiry and reset sequences.
module tb_disp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cur_valid;
    logic [11:0] cur_data;
    logic        dir;
    logic        cur_ready;
    logic        msg_valid;
    logic [15:0] msg_code;
    logic        msg_ready;
    logic [15:0] disp_digits;
    logic        disp_update;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_q;

`ifdef DISP_OVERRANGE_EN
    localparam logic [11:0] OVR = 12'hEEE;
`else
    localparam logic [11:0] OVR = 12'h999;
`endif

    typedef struct {
        logic [11:0] data;
        logic        dr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    disp_scheduler #(.MSG_HOLD_CYCLES(8), .CLAMP_MAX(999)) dut (
        .clk(clk), .rst_n(rst_n),
        .cur_valid(cur_valid), .cur_data(cur_data), .dir(dir), .cur_ready(cur_ready),
        .msg_valid(msg_valid), .msg_code(msg_code), .msg_ready(msg_ready),
        .disp_digits(disp_digits), .disp_update(disp_update), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every display update must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (disp_update === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_update", 32'(disp_digits), 32'hFFFF_FFFF);
            end else begin
                exp_q = sb.pop_front();
                chk("disp_digits", 32'(disp_digits), 32'(exp_q));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; transfer happens on the next posedge (T)
    task automatic do_cur(input logic [11:0] d, input logic dr, input logic [15:0] e);
        int bad;
        bad = 0;
        cur_valid = 1'b1; cur_data = d; dir = dr;
        #1;
        chk("cur_ready_idle", 32'(cur_ready), 32'd1);
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        cur_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cur_ready !== 1'b0 || disp_update !== 1'b0) bad++;
        end
        chk("convert_window", 32'(bad), 32'd0);
        @(negedge clk);
        chk("cur_latency", 32'({disp_update, busy}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{12'd457,  1'b0, 16'hB457};
        vecs[1] = '{12'd999,  1'b0, 16'hB999};
        vecs[2] = '{12'd1000, 1'b0, {4'hB, OVR}};
        vecs[3] = '{12'd10,   1'b0, 16'hB010};
        vecs[4] = '{12'd4095, 1'b1, {4'hA, OVR}};
        vecs[5] = '{12'd0,    1'b1, 16'hA000};
        vecs[6] = '{12'd123,  1'b1, 16'hA123};
        vecs[7] = '{12'd5,    1'b0, 16'hB005};

        rst_n = 1'b0; cur_valid = 1'b0; cur_data = '0; dir = 1'b0;
        msg_valid = 1'b0; msg_code = '0;
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(disp_digits), 32'hFFFF);
        chk("reset_flags", 32'({disp_update, busy, cur_ready, msg_ready}), 32'b0011);
        rst_n = 1'b1;

        // First vector goes in on the very first edge after reset release
        for (int i = 0; i < 8; i++)
            do_cur(vecs[i].data, vecs[i].dr, vecs[i].exp);

        // Simultaneous offers: message wins, current sample waits until hold expires
        wait_idle();
        msg_valid = 1'b1; msg_code = 16'hEEEE; cur_valid = 1'b1; cur_data = 12'd5; dir = 1'b0;
        #1;
        chk("both_offer_ready", 32'({cur_ready, msg_ready}), 32'b01);
        @(posedge clk);
        sb.push_back(16'hEEEE);
        @(negedge clk);
        msg_valid = 1'b0;
        chk("show_cur_ready", 32'(cur_ready), 32'd0);
        @(negedge clk);
        chk("msg_pulse_t1", 32'(disp_update), 32'd1);
        begin
            int bad;
            bad = 0;
            repeat (7) begin
                @(negedge clk);
                if (busy !== 1'b1 || cur_ready !== 1'b0) bad++;
            end
            chk("msg_hold_window", 32'(bad), 32'd0);
        end
        @(negedge clk);
        chk("msg_idle_t9", 32'({busy, cur_ready}), 32'b01);
        @(posedge clk);
        sb.push_back(16'hB005);
        @(negedge clk);
        cur_valid = 1'b0;
        wait_idle();

        // Retrigger at T+5: new message at T+6, idle at T+14
        msg_valid = 1'b1; msg_code = 16'h5555;
        @(posedge clk);
        sb.push_back(16'h5555);
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (4) @(negedge clk);
        msg_valid = 1'b1; msg_code = 16'h1234;
        #1;
        chk("retrig_ready", 32'(msg_ready), 32'd1);
        @(posedge clk);
        sb.push_back(16'h1234);
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        chk("retrig_pulse_t6", 32'(disp_update), 32'd1);
        repeat (7) @(negedge clk);
        chk("retrig_busy_t13", 32'(busy), 32'd1);
        @(negedge clk);
        chk("retrig_idle_t14", 32'(busy), 32'd0);

        // Transfer on the expiry cycle outranks expiry
        msg_valid = 1'b1; msg_code = 16'h7777;
        @(posedge clk);
        sb.push_back(16'h7777);
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (8) @(negedge clk);
        msg_valid = 1'b1; msg_code = 16'h4321;
        @(posedge clk);
        sb.push_back(16'h4321);
        @(negedge clk);
        msg_valid = 1'b0;
        chk("expiry_precedence", 32'(busy), 32'd1);
        @(negedge clk);
        chk("expiry_pulse", 32'(disp_update), 32'd1);
        repeat (7) @(negedge clk);
        chk("expiry_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("expiry_idle", 32'(busy), 32'd0);

        // Reset during conversion aborts without a pulse
        cur_valid = 1'b1; cur_data = 12'd777; dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_digits", 32'(disp_digits), 32'hFFFF);
        chk("abort_flags", 32'({disp_update, busy}), 32'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cur(12'd0, 1'b0, 16'hB000);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
